// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL field layout, mode and state encodings for timer_counter.
// Latency: n/a (constants and one pure decode function).
// Backpressure: n/a.
package timer_pkg;

  // Word select (byte address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  // CTRL field positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_BITS     = 4;

  // Mode encodings
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Timer sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_t;

  // Modes 10 and 11 are not defined and fall back to one-shot.
  function automatic logic [1:0] eff_mode(input logic [1:0] mode);
    return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter: programmable down-counting timer on the peripheral bus, drives one HWInt bit.
// Latency: Enable write at edge t -> LOAD after t+1, COUNT=PRESET after t+2, irq after t+2+max(PRESET,1).
// Backpressure: none; bus writes always accepted in one cycle, reads are combinational.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Addr,
  input  logic             We,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             IRQ
);

  logic [CTRL_BITS-1:0] ctrl;
  logic [WIDTH-1:0]     preset;
  logic [WIDTH-1:0]     count;
  logic                 irq_flag;
  state_t               state;

  logic ctrl_wr;
  logic preset_wr;
  logic enable;
  logic reload;
  logic terminal;

  assign ctrl_wr   = We && (Addr == ADDR_CTRL);
  assign preset_wr = We && (Addr == ADDR_PRESET);
  assign enable    = ctrl[CTRL_EN];
  assign reload    = (eff_mode(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB]) == MODE_RELOAD);

  // Terminal count: this edge sets the flag, and a simultaneous acknowledge loses to it.
  assign terminal  = (state == CNT) && enable && (count <= WIDTH'(1));

  // Mask is applied after the flag so software can poll a masked timer.
  assign IRQ = irq_flag & ctrl[CTRL_IM];

  // Register file and sequencing FSM; bus writes are applied last so they win over FSM updates.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else begin
      // PRESET only reaches COUNT at the next LOAD, so an active countdown is untouched.
      if (preset_wr) begin
        preset <= WD;
      end

      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (reload) begin
            // Dropping the flag here makes IRQ a single-cycle pulse per period.
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            // One-shot: self-disable, flag stays up until software acknowledges.
            ctrl[CTRL_EN] <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Any CTRL write acknowledges; writing Enable=0 parks the FSM with COUNT frozen.
      if (ctrl_wr) begin
        ctrl <= WD[CTRL_BITS-1:0];
        if (!terminal) begin
          irq_flag <= 1'b0;
        end
        if (!WD[CTRL_EN]) begin
          state <= IDLE;
        end
      end
    end
  end

  // Combinational read mux; reserved word and unused CTRL bits read as zero.
  always_comb begin
    RD = '0;
    case (Addr)
      ADDR_CTRL:   RD = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl};
      ADDR_PRESET: RD = preset;
      ADDR_COUNT:  RD = count;
      default:     RD = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench for timer_counter against a timeline-based reference model.
// Latency: one expectation per bus cycle, checked on the falling edge before the next rising edge.
// Backpressure: n/a.
module tb_timer_counter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [1:0]   addr;
  logic         we;
  logic [W-1:0] wd;
  logic [W-1:0] rd;
  logic         irq;

  timer_counter #(.WIDTH(W)) dut (
    .Clk  (clk),
    .Rst  (rst),
    .Addr (addr),
    .We   (we),
    .WD   (wd),
    .RD   (rd),
    .IRQ  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned  tag;
    logic [1:0]   addr;
    logic [W-1:0] rd;
    logic         irq;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned tag         = 0;

  // Reference model: the countdown is described by absolute edge numbers rather than a state register.
  // m_load_at = edge at which COUNT takes PRESET, m_fire_at = edge at which the flag rises.
  logic [3:0]   m_ctrl;
  logic [W-1:0] m_preset;
  logic [W-1:0] m_count;   // held value while idle, waiting for load, or after firing
  logic [W-1:0] m_p;       // preset captured at load
  logic         m_flag;
  logic         m_active;
  longint       mn;        // index of the most recent rising edge
  longint       m_load_at;
  longint       m_fire_at;

  task automatic model_reset();
    m_ctrl    = '0;
    m_preset  = '0;
    m_count   = '0;
    m_p       = '0;
    m_flag    = 1'b0;
    m_active  = 1'b0;
    m_load_at = 0;
    m_fire_at = 0;
  endtask

  function automatic logic [W-1:0] cnt_at(input longint n);
    longint left;
    if (!m_active || n < m_load_at) return m_count;
    if (n >= m_fire_at) return '0;
    left = m_fire_at - n;
    if (left > longint'(m_p)) return m_p;
    return W'(left);
  endfunction

  function automatic logic [W-1:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {{(W-4){1'b0}}, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return cnt_at(mn);
      default: return '0;
    endcase
  endfunction

  // Advance the model across one rising edge given the bus op presented before it.
  task automatic model_step(input logic w, input logic [1:0] a, input logic [W-1:0] d);
    logic   en;
    logic   rel;
    logic   tc;
    longint n;
    n   = mn;
    en  = m_ctrl[0];
    rel = (m_ctrl[2:1] == 2'b01);
    tc  = 1'b0;
    if (!m_active) begin
      if (en) begin
        m_active  = 1'b1;
        m_load_at = n + 2;
      end
    end else if (n < m_load_at) begin
      m_p       = m_preset;
      m_fire_at = m_load_at + ((m_preset == '0) ? 64'sd1 : longint'(m_preset));
    end else if (n == m_fire_at) begin
      m_count = '0;
      if (rel) begin
        m_flag    = 1'b0;
        m_load_at = n + 2;
      end else begin
        m_ctrl[0] = 1'b0;
        m_active  = 1'b0;
      end
    end else if (!en) begin
      m_count  = cnt_at(n);
      m_active = 1'b0;
    end else if (n + 1 == m_fire_at) begin
      m_flag = 1'b1;
      tc     = 1'b1;
    end
    if (w && a == 2'd1) m_preset = d;
    if (w && a == 2'd0) begin
      if (!tc) m_flag = 1'b0;
      m_ctrl = d[3:0];
      if (!d[0] && m_active) begin
        m_count  = cnt_at(n + 1);
        m_active = 1'b0;
      end
    end
    mn = n + 1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rd) begin
          miscompares++;
          $display("FAIL rd #%0d addr=%0d: got %h, expected %h", e.tag, e.addr, rd, e.rd);
        end
        vectors++;
        if (irq !== e.irq) begin
          miscompares++;
          $display("FAIL irq #%0d: got %b, expected %b", e.tag, irq, e.irq);
        end
      end
    end
  endtask

  // One bus cycle: drive, push expectation for the current state, clock, advance model.
  task automatic cycle(input logic w, input logic [1:0] a, input logic [W-1:0] d);
    exp_t e;
    we   = w;
    addr = a;
    wd   = d;
    e.tag  = tag;
    e.addr = a;
    e.rd   = model_read(a);
    e.irq  = m_flag & m_ctrl[3];
    sb.push_back(e);
    tag++;
    @(posedge clk);
    #1;
    model_step(w, a, d);
  endtask

  task automatic idle();
    cycle(1'b0, 2'($urandom_range(0, 3)), W'($urandom));
  endtask

  task automatic run_until_count(input logic [W-1:0] v, input int budget);
    int k;
    k = 0;
    while (cnt_at(mn) != v && k < budget) begin
      cycle(1'b0, 2'd2, '0);
      k++;
    end
    if (cnt_at(mn) != v) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_count: count %0d, needed %0d within %0d cycles", cnt_at(mn), v, budget);
    end
  endtask

  task automatic run_until_tc(input int budget);
    int k;
    k = 0;
    while (!(m_active && m_ctrl[0] && mn >= m_load_at && mn + 1 == m_fire_at) && k < budget) begin
      cycle(1'b0, 2'd2, '0);
      k++;
    end
    if (!(m_active && mn + 1 == m_fire_at)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tc: terminal edge not reached, got none, expected within %0d cycles", budget);
    end
  endtask

  // Asynchronous reset: all reads and IRQ must clear before any clock edge.
  task automatic reset_check(input string name);
    we  = 1'b0;
    wd  = '0;
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("%s_rd%0d", name, a), rd, model_read(2'(a)));
    end
    chk({name, "_irq"}, {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, m_flag & m_ctrl[3]});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    rst  = 1'b0;
    we   = 1'b0;
    addr = 2'd0;
    wd   = '0;
    mn   = 0;
    model_reset();
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;
    reset_check("por");

    // One-shot, PRESET=5, then acknowledge with IM kept
    cycle(1'b1, 2'd1, 32'd5);
    cycle(1'b1, 2'd0, 32'h9);
    repeat (30) idle();
    cycle(1'b1, 2'd0, 32'h8);
    repeat (4) idle();

    // Auto-reload, PRESET=3, then PRESET=9 mid-count
    cycle(1'b1, 2'd1, 32'd3);
    cycle(1'b1, 2'd0, 32'hB);
    repeat (22) idle();
    run_until_count(32'd2, 10);
    cycle(1'b1, 2'd1, 32'd9);
    repeat (30) idle();
    cycle(1'b1, 2'd0, 32'h8);

    // Masked flag, then acknowledge with IM set
    cycle(1'b1, 2'd1, 32'd2);
    cycle(1'b1, 2'd0, 32'h1);
    repeat (8) idle();
    cycle(1'b1, 2'd0, 32'h9);
    repeat (3) idle();
    cycle(1'b1, 2'd0, 32'h0);

    // PRESET=0 behaves like PRESET=1
    cycle(1'b1, 2'd1, 32'd0);
    cycle(1'b1, 2'd0, 32'h9);
    repeat (6) idle();
    cycle(1'b1, 2'd0, 32'h8);

    // Disable mid-count, then re-enable
    cycle(1'b1, 2'd1, 32'd10);
    cycle(1'b1, 2'd0, 32'h9);
    run_until_count(32'd6, 20);
    cycle(1'b1, 2'd0, 32'h8);
    repeat (5) idle();
    cycle(1'b1, 2'd0, 32'h9);
    repeat (16) idle();
    cycle(1'b1, 2'd0, 32'h8);

    // CTRL write on the terminal-count edge
    cycle(1'b1, 2'd1, 32'd4);
    cycle(1'b1, 2'd0, 32'h9);
    run_until_tc(20);
    cycle(1'b1, 2'd0, 32'h9);
    repeat (4) idle();
    cycle(1'b1, 2'd0, 32'h8);

    // Writes to COUNT and reserved word are ignored
    cycle(1'b1, 2'd1, 32'd6);
    cycle(1'b1, 2'd0, 32'h9);
    repeat (3) idle();
    cycle(1'b1, 2'd2, 32'hDEAD_BEEF);
    cycle(1'b1, 2'd3, 32'h1234_5678);
    cycle(1'b0, 2'd3, '0);
    cycle(1'b0, 2'd2, '0);
    repeat (8) idle();
    cycle(1'b1, 2'd0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          cycle(1'b1, 2'd1, W'($urandom_range(0, 9)));
        end else begin
          d    = W'($urandom);
          d[0] = ($urandom_range(0, 3) != 0);
          cycle(1'b1, 2'($urandom_range(0, 3) == 0 ? $urandom_range(2, 3) : 0), d);
        end
      end else begin
        idle();
      end
    end

    // Reset mid-count with COUNT=7
    cycle(1'b1, 2'd1, 32'd20);
    cycle(1'b1, 2'd0, 32'h9);
    run_until_count(32'd7, 30);
    reset_check("mid");
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Programmable down-counting timer device on the CPU's peripheral bus. It is the interrupt source that drives one bit of CP0's HWInt vector.
- Software writes PRESET and CTRL with sw through the bridge.
- The block counts down and raises IRQ at terminal count.
- Two modes: one-shot (level IRQ held until acknowledged) and auto-reload (periodic 1-cycle IRQ pulse).

Parameters:
WIDTH, 32, bit width of the PRESET and COUNT registers and of the bus data.

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  asynchronous, active-low reset (0 = reset)
Addr  input  2  word select, byte address bits [3:2]: 00=CTRL, 01=PRESET, 10=COUNT, 11=reserved
We  input  1  bus write enable, sampled on rising edge
WD  input  WIDTH  bus write data
RD  output  WIDTH  combinational read data for Addr
IRQ  output  1  interrupt request, wired to one HWInt bit of CP0

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 Enable, bits[2:1] Mode (00 one-shot, 01 auto-reload, 10/11 behave as 00), bit3 IM (interrupt mask). CTRL[31:4] reads 0.
  - PRESET: read/write.
  - COUNT: read-only; writes to it are ignored.
  - Addr=11 reads 0; writes to it are ignored.
- Reset (Rst=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, IRQ=0.
  - Reset asserted mid-count aborts immediately; no IRQ is produced.
- IRQ = irq_flag & CTRL[3]. Purely combinational from registers, no pulse stretching.
- FSM states IDLE, LOAD, CNT, INT; one transition per edge:
  - IDLE: Enable=1 -> LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - Enable=0 -> IDLE, COUNT holds.
    - Else if COUNT>1: COUNT <= COUNT-1.
    - Else (COUNT<=1): COUNT <= 0, irq_flag <= 1 -> INT.
  - INT, mode 00: CTRL[0] <= 0 -> IDLE; irq_flag stays 1.
  - INT, mode 01: irq_flag <= 0 -> LOAD. This makes IRQ a 1-cycle pulse; the period is PRESET+2 cycles for PRESET>=1.
- Latency: write CTRL Enable=1 at edge t gives LOAD after t+1, COUNT=PRESET after t+2, irq_flag=1 after t+2+max(PRESET,1).
- Acknowledge: any CTRL write clears irq_flag.
  - A terminal-count set in the same edge wins (flag=1).
  - A CTRL write in the same edge as the INT-state Enable auto-clear wins; CTRL takes WD.
- Any CTRL write with Enable=0 forces the next state to IDLE from any state. COUNT holds its value.
- A PRESET write takes effect only at the next LOAD; an in-progress count is unaffected.
- Changing Mode or IM mid-count takes effect from the next edge; no state reset.
- Bus write and count decrement in the same edge: both happen, because they touch different registers.

Decomposition:
- Shared package timer_pkg holds:
  - address constants ADDR_CTRL=2'b00, ADDR_PRESET=2'b01, ADDR_COUNT=2'b10;
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode encodings MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01;
  - state encoding IDLE/LOAD/CNT/INT as 2-bit constants.
- No sub-module is needed: register file, FSM and read mux form one module.

Test Plan:
- Reset: Rst=0 mid-count with COUNT=7 -> all of RD(CTRL/PRESET/COUNT)=0 and IRQ=0 immediately, before any clock edge.
- One-shot: PRESET=5, CTRL=0x9 -> IRQ rises exactly 7 edges after the CTRL write. Then COUNT=0, CTRL reads 0x8, IRQ stays 1 for 20 cycles. Writing CTRL=0x8 drops IRQ the next edge.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ is a 1-cycle pulse every 5 cycles, for 4 consecutive periods. Enable stays 1.
- Mask/edge cases:
  - CTRL=0x1 (IM=0), PRESET=2 -> irq_flag set but IRQ stays 0. A later CTRL write of 0x9 clears the flag, so IRQ stays 0.
  - PRESET=0 -> IRQ after 3 edges, same as PRESET=1.
- Disable mid-count: PRESET=10, enable, write CTRL=0x8 after COUNT reads 6 -> COUNT frozen at 5 or 6 per the edge timing above, no IRQ. Re-enabling reloads from PRESET.
- Simultaneous events:
  - A PRESET write of 9 during CNT does not change the current countdown; the next reload in mode 01 uses 9.
  - A CTRL write on the terminal-count edge leaves IRQ=1.
  - Writes to COUNT and to Addr=11 are ignored; reading Addr=11 returns 0.
